// File: rtl/bus_sequencer_if.sv
// Shared-bus sequencer handshake and register-control signal bundle.
// The master side issues requests and drives the bus tap; the slave side is the sequencer.
interface bus_sequencer_if #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned SEL_W     = 3
);
  logic                 REQ;
  logic [1:0]           OP;
  logic [SEL_W-1:0]     SRC_SEL;
  logic [SEL_W-1:0]     DST_SEL;
  logic [BUS_WIDTH-1:0] DATA;
  logic [NUM_REGS-1:0]  REG_ENABLE;
  logic [NUM_REGS-1:0]  REG_RW;
  logic [NUM_REGS-1:0]  REG_COUNT;
  logic [NUM_REGS-1:0]  REG_CLR;
  logic                 READY;
  logic                 DONE;
  logic                 ERR;
  logic [BUS_WIDTH-1:0] LAST_DATA;

  modport master (
    output REQ, OP, SRC_SEL, DST_SEL, DATA,
    input  REG_ENABLE, REG_RW, REG_COUNT, REG_CLR, READY, DONE, ERR, LAST_DATA
  );

  modport slave (
    input  REQ, OP, SRC_SEL, DST_SEL, DATA,
    output REG_ENABLE, REG_RW, REG_COUNT, REG_CLR, READY, DONE, ERR, LAST_DATA
  );
endinterface

// File: rtl/bus_sequencer.sv
// Sequences MOVE / INC / CLR operations over a shared register bus.
// Every output is a flop loaded with the value belonging to the next state.
module bus_sequencer #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned SEL_W     = 3
) (
  input logic                 CLOCK,
  input logic                 RESET_N,
  bus_sequencer_if.slave      bus
);

  localparam logic [1:0] OpMove = 2'b00;
  localparam logic [1:0] OpInc  = 2'b01;
  localparam logic [1:0] OpRsvd = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StLatch,
    StRelease,
    StStrobe,
    StFault
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     src_q, src_d;
  logic [SEL_W-1:0]     dst_q, dst_d;
  logic [1:0]           op_q, op_d;

  logic [NUM_REGS-1:0]  en_q, en_d;
  logic [NUM_REGS-1:0]  rw_q, rw_d;
  logic [NUM_REGS-1:0]  cnt_q, cnt_d;
  logic [NUM_REGS-1:0]  clr_q, clr_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [BUS_WIDTH-1:0] last_q;

  logic                 req_valid;
  logic [NUM_REGS-1:0]  src_oh, dst_oh;

  always_comb begin
    req_valid = (bus.OP != OpRsvd) && (32'(bus.DST_SEL) < NUM_REGS);
    if (bus.OP == OpMove) begin
      req_valid = req_valid && (32'(bus.SRC_SEL) < NUM_REGS) && (bus.SRC_SEL != bus.DST_SEL);
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ) begin
          src_d = bus.SRC_SEL;
          dst_d = bus.DST_SEL;
          op_d  = bus.OP;
          if (!req_valid)             state_d = StFault;
          else if (bus.OP == OpMove)  state_d = StDrive;
          else                        state_d = StStrobe;
        end
      end
      StDrive:   state_d = StLatch;
      StLatch:   state_d = StRelease;
      StStrobe:  state_d = StRelease;
      StRelease: state_d = StIdle;
      StFault:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output values for the state being entered, so the flops present them with no input path.
  always_comb begin
    src_oh  = NUM_REGS'(1) << src_d;
    dst_oh  = NUM_REGS'(1) << dst_d;
    en_d    = '0;
    rw_d    = '1;
    cnt_d   = '0;
    clr_d   = '0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_d)
      StIdle:    ready_d = 1'b1;
      StDrive:   en_d    = src_oh;
      StLatch: begin
        en_d = src_oh | dst_oh;
        rw_d = ~dst_oh;
      end
      StRelease: done_d  = 1'b1;
      StStrobe: begin
        if (op_d == OpInc) cnt_d = dst_oh;
        else               clr_d = dst_oh;
      end
      StFault:   err_d   = 1'b1;
      default:   ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      op_q    <= '0;
      en_q    <= '0;
      rw_q    <= '1;
      cnt_q   <= '0;
      clr_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      op_q    <= op_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (state_q == StLatch) last_q <= bus.DATA;
    end
  end

  assign bus.REG_ENABLE = en_q;
  assign bus.REG_RW     = rw_q;
  assign bus.REG_COUNT  = cnt_q;
  assign bus.REG_CLR    = clr_q;
  assign bus.READY      = ready_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.LAST_DATA  = last_q;

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of bidirectional registers on the shared bus.
REQ-002 SHALL have parameter BUS_WIDTH, default 16, data bus width.
REQ-003 SHALL have parameter SEL_W, default 3, select width; NUM_REGS <= 2^SEL_W.
REQ-004 SHALL have port CLOCK, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port REQ, input, 1, operation request, sampled only while READY=1.
REQ-007 SHALL have port OP, input, 2, operation: 00 MOVE, 01 INC, 10 CLR, 11 reserved.
REQ-008 SHALL have port SRC_SEL, input, SEL_W, source register index (MOVE only).
REQ-009 SHALL have port DST_SEL, input, SEL_W, destination register index.
REQ-010 SHALL have port DATA, input, BUS_WIDTH, monitor tap of shared bus.
REQ-011 SHALL have port REG_ENABLE, output, NUM_REGS, per-register bus enable.
REQ-012 SHALL have port REG_RW, output, NUM_REGS, per-register RW (0 read bus, 1 write bus).
REQ-013 SHALL have port REG_COUNT, output, NUM_REGS, per-register increment strobe.
REQ-014 SHALL have port REG_CLR, output, NUM_REGS, per-register synchronous clear strobe.
REQ-015 SHALL have port READY, output, 1, high when idle and able to accept REQ.
REQ-016 SHALL have port DONE, output, 1, one-cycle pulse on operation completion.
REQ-017 SHALL have port ERR, output, 1, one-cycle pulse on rejected request.
REQ-018 SHALL have port LAST_DATA, output, BUS_WIDTH, bus value captured on last MOVE.

Function
REQ-019 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-020 SHALL implement states IDLE, DRIVE, LATCH, RELEASE, STROBE, FAULT.
REQ-021 SHALL accept a request on an edge where REQ=1 and READY=1; READY SHALL be 1 only in IDLE.
REQ-022 SHALL reject (IDLE->FAULT) if OP=11, DST_SEL>=NUM_REGS, or MOVE with SRC_SEL>=NUM_REGS or SRC_SEL=DST_SEL.
REQ-023 SHALL in FAULT assert ERR for one cycle with all strobes/enables 0, then return to IDLE.
REQ-024 SHALL on valid MOVE go IDLE->DRIVE: REG_ENABLE[src]=1, REG_RW[src]=1.
REQ-025 SHALL go DRIVE->LATCH: keep src enabled/writing, add REG_ENABLE[dst]=1, REG_RW[dst]=0.
REQ-026 SHALL go LATCH->RELEASE: capture DATA into LAST_DATA at this edge, clear all REG_ENABLE, assert DONE.
REQ-027 SHALL go RELEASE->IDLE unconditionally; MOVE accept-to-DONE latency 3 cycles, accept-to-READY 4 cycles.
REQ-028 SHALL on valid INC or CLR go IDLE->STROBE: REG_COUNT[dst]=1 (INC) or REG_CLR[dst]=1 (CLR), REG_ENABLE all 0, for exactly one cycle.
REQ-029 SHALL go STROBE->RELEASE (DONE=1) -> IDLE; latency accept-to-DONE 2 cycles.
REQ-030 SHALL hold REG_RW=1 for every register not currently selected as MOVE destination.
REQ-031 SHALL never assert more than one REG_RW=0 bit, nor REG_ENABLE with REG_RW=1 on more than one register.
REQ-032 SHALL ignore REQ and input selects while not in IDLE; selects latched at accept.
REQ-033 SHALL hold LAST_DATA unchanged except at the LATCH->RELEASE edge.
REQ-034 SHALL never assert DONE and ERR in the same cycle.

Reset
REQ-035 SHALL on RESET_N=0, immediately and regardless of CLOCK: state IDLE, REG_ENABLE=0, REG_RW=all 1, REG_COUNT=0, REG_CLR=0, DONE=0, ERR=0, LAST_DATA=0.
REQ-036 SHALL assert READY=1 on the first cycle after RESET_N deasserts; reset mid-operation aborts it with no DONE.

Verification
REQ-037 MOVE src=2 dst=5, bus model drives 16'hA5C3 from reg2 -> ENABLE[2]/RW[2]=1 for 2 cycles, ENABLE[5] RW[5]=0 1 cycle, DONE at cycle 3, LAST_DATA=16'hA5C3.
REQ-038 INC dst=7 -> REG_COUNT=8'h80 for one cycle, REG_ENABLE=0 throughout, DONE at cycle 2.
REQ-039 MOVE src=3 dst=3, and OP=11 -> ERR one cycle each, no enable/strobe activity, READY back next cycle.
REQ-040 REQ held high continuously with valid MOVEs -> back-to-back accepts every 4 cycles, REQ ignored while READY=0.
REQ-041 RESET_N low during LATCH -> outputs at reset values asynchronously, no DONE, LAST_DATA=0.
REQ-042 NUM_REGS=6, DST_SEL=6 -> ERR, no strobes.
